// File: rtl/game_referee_pkg.sv
// Shared types and defaults for the game referee: FSM states, verdict codes and
// helpers that map raw collision flags to a single verdict and back to output flags.
package game_referee_pkg;

   typedef enum logic [1:0] {MENU, GAME, PAUSE, GAME_OVER} game_mode;
   typedef enum logic [1:0] {IDLE, PLAY, CONFIRM, ENDED} ref_state_t;
   typedef enum logic [1:0] {V_NONE, V_WON, V_LOST, V_DRAW} verdict_t;

   localparam int DEF_WIN_SCORE     = 20;
   localparam int DEF_SCORE_W       = 8;
   localparam int DEF_CONFIRM_TICKS = 2;

   // raw is {won, lost, draw}; won and lost together means both snakes died at once
   function automatic verdict_t decode_verdict(input logic [2:0] raw);
      verdict_t v;
      v = V_NONE;
      if (raw[0] || (raw[2] && raw[1])) v = V_DRAW;
      else if (raw[2])                  v = V_WON;
      else if (raw[1])                  v = V_LOST;
      return v;
   endfunction

   function automatic logic [2:0] verdict_flags(input verdict_t v);
      logic [2:0] f;
      case (v)
         V_WON:   f = 3'b100;
         V_LOST:  f = 3'b010;
         V_DRAW:  f = 3'b001;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/game_referee_score_counter.sv
// Per-player score: sticky food-event latch consumed on each game tick, saturating
// add up to WIN_SCORE, synchronous clear. score_nxt exposes the post-tick value.
module game_referee_score_counter
   import game_referee_pkg::*;
#(
   parameter int SCORE_W   = DEF_SCORE_W,
   parameter int WIN_SCORE = DEF_WIN_SCORE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               en,
   input  logic               clr,
   input  logic               eaten,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] score_nxt
);

   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   logic               eaten_prev_q, eaten_prev_d;
   logic               sticky_q, sticky_d;
   logic [SCORE_W-1:0] score_q, score_d;

   always_comb begin
      eaten_prev_d = eaten;
      // an edge arriving on the tick cycle itself still counts for that tick
      sticky_d     = sticky_q | (eaten & ~eaten_prev_q);
      score_d      = score_q;
      if (clr) begin
         sticky_d = 1'b0;
         score_d  = '0;
      end else if (tick) begin
         if (en && sticky_d && (score_q < WIN)) score_d = score_q + 1'b1;
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eaten_prev_q <= 1'b0;
         sticky_q     <= 1'b0;
         score_q      <= '0;
      end else begin
         eaten_prev_q <= eaten_prev_d;
         sticky_q     <= sticky_d;
         score_q      <= score_d;
      end
   end

   assign score     = score_q;
   assign score_nxt = score_d;

endmodule

// File: rtl/game_referee.sv
// Game referee: accumulates food scores, debounces raw collision verdicts over
// CONFIRM_TICKS game ticks and holds the final won/lost/draw until mode leaves GAME.
// Optional per-match tally outputs wins1/wins2 are enabled by MATCH_TALLY_EN.
module game_referee
   import game_referee_pkg::*;
#(
   parameter int WIN_SCORE     = DEF_WIN_SCORE,
   parameter int SCORE_W       = DEF_SCORE_W,
   parameter int CONFIRM_TICKS = DEF_CONFIRM_TICKS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_div,
   input  game_mode           mode,
   input  logic               eaten1,
   input  logic               eaten2,
   input  logic               raw_won,
   input  logic               raw_lost,
   input  logic               raw_draw,
   input  logic               con_error,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               won,
   output logic               lost,
   output logic               draw
`ifdef MATCH_TALLY_EN
  ,output logic [SCORE_W-1:0] wins1,
   output logic [SCORE_W-1:0] wins2
`endif
);

   localparam int                 CNT_W = $clog2(CONFIRM_TICKS + 1);
   localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

   logic             div_q, div_d;
   logic             tick_q, tick_d;
   ref_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       vec_q, vec_d;
   logic [2:0]       flags_q, flags_d;

   logic [2:0]         raw_vec;
   logic               in_game, cnt_en, clr, hit1, hit2;
   logic [SCORE_W-1:0] s1_nxt, s2_nxt;
   verdict_t           fin;

   assign raw_vec = {raw_won, raw_lost, raw_draw};
   assign in_game = (mode == GAME);
   assign cnt_en  = (state_q == PLAY) || (state_q == CONFIRM);
   // scores are zero whenever the FSM is in, or about to enter, IDLE
   assign clr     = con_error || !in_game || (state_q == IDLE);
   assign hit1    = (s1_nxt == WIN);
   assign hit2    = (s2_nxt == WIN);

   game_referee_score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score1 (
      .clk(clk), .rst_n(rst_n), .tick(tick_q), .en(cnt_en), .clr(clr),
      .eaten(eaten1), .score(score1), .score_nxt(s1_nxt)
   );

   game_referee_score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score2 (
      .clk(clk), .rst_n(rst_n), .tick(tick_q), .en(cnt_en), .clr(clr),
      .eaten(eaten2), .score(score2), .score_nxt(s2_nxt)
   );

   always_comb begin
      div_d   = clk_div;
      tick_d  = clk_div & ~div_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      flags_d = flags_q;
      fin     = V_NONE;
      if (con_error) begin
         state_d = IDLE;
         cnt_d   = '0;
         vec_d   = '0;
         flags_d = '0;
      end else begin
         unique case (state_q)
            IDLE: if (in_game) state_d = PLAY;
            PLAY, CONFIRM: begin
               if (!in_game) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  vec_d   = '0;
               end else if (tick_q) begin
                  // a score-based finish outranks any verdict seen on the same tick
                  if (hit1 && hit2)  fin = V_DRAW;
                  else if (hit1)     fin = V_WON;
                  else if (hit2)     fin = V_LOST;
                  else if (state_q == PLAY) begin
                     if (raw_vec != 3'b000) begin
                        state_d = CONFIRM;
                        cnt_d   = CNT_W'(1);
                        vec_d   = raw_vec;
                        if (CONFIRM_TICKS <= 1) fin = decode_verdict(raw_vec);
                     end
                  end else if (raw_vec == vec_q) begin
                     cnt_d = cnt_q + 1'b1;
                     if (cnt_d == CNT_W'(CONFIRM_TICKS)) fin = decode_verdict(vec_q);
                  end else begin
                     state_d = PLAY;
                     cnt_d   = '0;
                     vec_d   = '0;
                  end
                  if (fin != V_NONE) begin
                     state_d = ENDED;
                     cnt_d   = '0;
                     vec_d   = '0;
                     flags_d = verdict_flags(fin);
                  end
               end
            end
            ENDED: begin
               if (!in_game) begin
                  state_d = IDLE;
                  flags_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef MATCH_TALLY_EN
   logic [SCORE_W-1:0] wins1_q, wins1_d;
   logic [SCORE_W-1:0] wins2_q, wins2_d;

   always_comb begin
      wins1_d = wins1_q;
      wins2_d = wins2_q;
      if ((state_q != ENDED) && (state_d == ENDED)) begin
         if (flags_d[2] && (wins1_q != '1)) wins1_d = wins1_q + 1'b1;
         if (flags_d[1] && (wins2_q != '1)) wins2_d = wins2_q + 1'b1;
      end
   end

   assign wins1 = wins1_q;
   assign wins2 = wins2_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= 1'b0;
         tick_q  <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         flags_q <= '0;
`ifdef MATCH_TALLY_EN
         wins1_q <= '0;
         wins2_q <= '0;
`endif
      end else begin
         div_q   <= div_d;
         tick_q  <= tick_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         flags_q <= flags_d;
`ifdef MATCH_TALLY_EN
         wins1_q <= wins1_d;
         wins2_q <= wins2_d;
`endif
      end
   end

   assign won  = flags_q[2];
   assign lost = flags_q[1];
   assign draw = flags_q[0];

endmodule

// File: tb/tb_game_referee.sv
// Directed and randomized checks of game_referee against a tick-level game model
// (scores, pending verdict run length, final result) kept in the bench.
module tb_game_referee;
   import game_referee_pkg::*;

   localparam int W  = 6;
   localparam int SW = 8;
   localparam int CT = 2;

   logic          clk = 1'b0, rst_n = 1'b0, clk_div = 1'b0;
   logic          eaten1 = 1'b0, eaten2 = 1'b0;
   logic          raw_won = 1'b0, raw_lost = 1'b0, raw_draw = 1'b0, con_error = 1'b0;
   game_mode      mode = MENU;
   logic [SW-1:0] score1, score2;
   logic          won, lost, draw;
`ifdef MATCH_TALLY_EN
   logic [SW-1:0] wins1, wins2;
`endif

   int         n_pass = 0, n_fail = 0, n_total = 0;
   int         m_s1 = 0, m_s2 = 0, m_len = 0;
   logic [2:0] m_res = 3'b000, m_pend = 3'b000, rv = 3'b000;

   game_referee #(.WIN_SCORE(W), .SCORE_W(SW), .CONFIRM_TICKS(CT)) dut (
      .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .mode(mode),
      .eaten1(eaten1), .eaten2(eaten2),
      .raw_won(raw_won), .raw_lost(raw_lost), .raw_draw(raw_draw),
      .con_error(con_error),
      .score1(score1), .score2(score2), .won(won), .lost(lost), .draw(draw)
`ifdef MATCH_TALLY_EN
     ,.wins1(wins1), .wins2(wins2)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] ref_flags(input logic [2:0] r);
      if (r[0] || (r[2] && r[1])) return 3'b001;
      else if (r[2])              return 3'b100;
      else                        return 3'b010;
   endfunction

   task automatic model_clear();
      m_s1 = 0; m_s2 = 0; m_len = 0; m_pend = 3'b000; m_res = 3'b000;
   endtask

   // One game tick under the rules: score first, then verdict persistence.
   task automatic model_tick(input bit e1, input bit e2, input logic [2:0] r);
      if (m_res != 3'b000) return;
      m_s1 = (m_s1 + int'(e1) > W) ? W : m_s1 + int'(e1);
      m_s2 = (m_s2 + int'(e2) > W) ? W : m_s2 + int'(e2);
      if (m_s1 == W && m_s2 == W) m_res = 3'b001;
      else if (m_s1 == W)         m_res = 3'b100;
      else if (m_s2 == W)         m_res = 3'b010;
      else if (m_len == 0) begin
         if (r != 3'b000) begin
            m_pend = r;
            m_len  = 1;
            if (m_len >= CT) m_res = ref_flags(r);
         end
      end else if (r == m_pend) begin
         m_len++;
         if (m_len == CT) m_res = ref_flags(m_pend);
      end else m_len = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_score1"}, 32'(score1), 32'(m_s1));
      check({tag, "_score2"}, 32'(score2), 32'(m_s2));
      check({tag, "_flags"},  32'({won, lost, draw}), 32'(m_res));
   endtask

   // Food pulses 3 clk wide, then a clk_div rising edge; flags sampled just before
   // and just after the clock where the tick takes effect.
   task automatic tick(input bit e1, input bit e2, input logic [2:0] r);
      logic [2:0] pre, exp_pre;
      eaten1 = e1; eaten2 = e2; {raw_won, raw_lost, raw_draw} = r;
      repeat (3) @(negedge clk);
      eaten1 = 1'b0; eaten2 = 1'b0;
      @(negedge clk); clk_div = 1'b1;
      @(negedge clk); pre = {won, lost, draw};
      @(negedge clk);
      exp_pre = m_res;
      model_tick(e1, e2, r);
      check("pre_tick_flags", 32'(pre), 32'(exp_pre));
      check_all("tick");
      clk_div = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic menu_and_back();
      mode = MENU; @(negedge clk);
      model_clear();
      check_all("menu_clear");
      mode = GAME; @(negedge clk);
   endtask

   task automatic pulse_con_error();
      con_error = 1'b1; @(negedge clk);
      con_error = 1'b0;
      model_clear();
      check_all("con_error_clear");
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1; @(negedge clk);
      mode = GAME; @(negedge clk);

      repeat (5) tick(1'b1, 1'b0, 3'b000);
      check("five_food_score1", 32'(score1), 32'd5);
      check("five_food_verdicts", 32'({won, lost, draw}), 32'd0);
      menu_and_back();

      repeat (W) tick(1'b0, 1'b1, 3'b000);
      check("score_lost", 32'(lost), 32'd1);
      repeat (2) tick(1'b0, 1'b1, 3'b000);
      check("score2_saturated", 32'(score2), 32'(W));
      menu_and_back();
      check("menu_clears_lost", 32'(lost), 32'd0);

      tick(1'b0, 1'b0, 3'b100);
      tick(1'b0, 1'b0, 3'b000);
      check("single_tick_no_won", 32'(won), 32'd0);
      tick(1'b0, 1'b0, 3'b100);
      tick(1'b0, 1'b0, 3'b100);
      check("confirmed_won", 32'(won), 32'd1);
      menu_and_back();

      tick(1'b0, 1'b0, 3'b110);
      tick(1'b0, 1'b0, 3'b110);
      check("won_lost_is_draw", 32'({won, lost, draw}), 32'b001);
      menu_and_back();

      tick(1'b1, 1'b0, 3'b000);
      tick(1'b0, 1'b0, 3'b010);
      pulse_con_error();

      for (int i = 0; i < 150; i++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r == 0) pulse_con_error();
         else if (r == 1 || (m_res != 3'b000 && r < 8)) menu_and_back();
         else begin
            if ($urandom_range(0, 9) >= 5)
               rv = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), rv);
         end
      end

      menu_and_back();
      repeat (5) tick(1'b1, 1'b0, 3'b000);
      tick(1'b0, 1'b0, 3'b100);
      tick(1'b0, 1'b0, 3'b100);
      check("ended_won_before_reset", 32'(won), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_score1", 32'(score1), 32'd0);
      check("async_reset_flags", 32'({won, lost, draw}), 32'd0);
      model_clear();
      rst_n = 1'b1;
      @(negedge clk);
      check_all("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
